// File: rtl/cim_pkg.sv
// Shared types and sizing helpers for the bit-serial CIM crossbar tile.
package cim_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, ACCUM} state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned obuf_data_size(input int unsigned data_size,
                                                   input int unsigned xbar_size);
        return 2 * data_size + $clog2(xbar_size);
    endfunction

endpackage

// File: rtl/cim_xbar_weights.sv
// Weight store for one crossbar tile: single-entry write port, full-row combinational read.
module cim_xbar_weights
    import cim_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 4,
    parameter int unsigned XBAR_SIZE = 16,
    parameter int unsigned ELEMENTS  = 4,
    localparam int unsigned RW = $clog2(XBAR_SIZE),
    localparam int unsigned CW = clog2_min1(ELEMENTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          we_i,
    input  logic [RW-1:0]                 row_i,
    input  logic [CW-1:0]                 col_i,
    input  logic [DATA_SIZE-1:0]          data_i,
    input  logic [RW-1:0]                 rd_row_i,
    output logic [ELEMENTS*DATA_SIZE-1:0] rd_data_o
);

    logic [DATA_SIZE-1:0] w_q [XBAR_SIZE][ELEMENTS];

    // Out-of-range row/col never matches an entry, so such writes drop naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < XBAR_SIZE; r++) begin
                for (int c = 0; c < ELEMENTS; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else if (we_i) begin
            for (int r = 0; r < XBAR_SIZE; r++) begin
                for (int c = 0; c < ELEMENTS; c++) begin
                    if (int'(row_i) == r && int'(col_i) == c) begin
                        w_q[r][c] <= data_i;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < ELEMENTS; c++) begin
            rd_data_o[c*DATA_SIZE +: DATA_SIZE] = w_q[rd_row_i][c];
        end
    end

endmodule

// File: rtl/cim_xbar_tile.sv
// Bit-serial CIM crossbar tile: one input bit-plane per start, shifted accumulation per column,
// results served through an address-indexed output-buffer read port.
module cim_xbar_tile
    import cim_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = 4,
    parameter int unsigned XBAR_SIZE      = 16,
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned OBUF_BUS_WIDTH = 24,
    localparam int unsigned OBUF_DATA_SIZE = obuf_data_size(DATA_SIZE, XBAR_SIZE),
    localparam int unsigned ELEMENTS       = XBAR_SIZE / DATA_SIZE,
    localparam int unsigned NUM_CHANNELS   = OBUF_BUS_WIDTH / OBUF_DATA_SIZE,
    localparam int unsigned NUM_ADDR       = XBAR_SIZE / BUS_WIDTH,
    localparam int unsigned NUM_ADDR_OBUF  = (ELEMENTS + NUM_CHANNELS - 1) / NUM_CHANNELS,
    localparam int unsigned AW             = clog2_min1(NUM_ADDR),
    localparam int unsigned RW             = $clog2(XBAR_SIZE),
    localparam int unsigned CW             = clog2_min1(ELEMENTS),
    localparam int unsigned OAW            = clog2_min1(NUM_ADDR_OBUF)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_we,
    input  logic [AW-1:0]                          i_addr,
    input  logic [BUS_WIDTH-1:0]                   i_data,
    input  logic                                   i_start,
    output logic                                   o_ready,
    input  logic                                   i_w_we,
    input  logic [RW-1:0]                          i_w_row,
    input  logic [CW-1:0]                          i_w_col,
    input  logic [DATA_SIZE-1:0]                   i_w_data,
    input  logic [OAW-1:0]                         i_obuf_addr,
    output logic [NUM_CHANNELS*OBUF_DATA_SIZE-1:0] o_data
);

    localparam int unsigned PW   = DATA_SIZE + RW + 1;
    localparam int unsigned PLW  = clog2_min1(DATA_SIZE);
    localparam int unsigned RowW = ELEMENTS * DATA_SIZE;

    state_e                    state_q;
    logic                      ready_q;
    logic [XBAR_SIZE-1:0]      in_q;
    logic [RW-1:0]             row_q;
    logic [PLW-1:0]            plane_q;
    logic                      fetch_done_q;
    logic                      stage_vld_q;
    logic [RowW-1:0]           stage_q;
    logic [PW-1:0]             psum_q [ELEMENTS];
    logic [OBUF_DATA_SIZE-1:0] acc_q  [ELEMENTS];
    logic [OBUF_DATA_SIZE-1:0] acc_d  [ELEMENTS];
    logic [OBUF_DATA_SIZE:0]   acc_sum [ELEMENTS];
    logic [RowW-1:0]           w_row;

    cim_xbar_weights #(
        .DATA_SIZE (DATA_SIZE),
        .XBAR_SIZE (XBAR_SIZE),
        .ELEMENTS  (ELEMENTS)
    ) u_weights (
        .clk_i     (clk),
        .rst_ni    (rst),
        .we_i      (i_w_we && (state_q == IDLE)),
        .row_i     (i_w_row),
        .col_i     (i_w_col),
        .data_i    (i_w_data),
        .rd_row_i  (row_q),
        .rd_data_o (w_row)
    );

    // Plane 0 overwrites so a new inference needs no explicit clear.
    always_comb begin
        for (int c = 0; c < ELEMENTS; c++) begin
            acc_sum[c] = (OBUF_DATA_SIZE + 1)'(acc_q[c])
                       + ((OBUF_DATA_SIZE + 1)'(psum_q[c]) << plane_q);
            acc_d[c]   = (plane_q == '0) ? OBUF_DATA_SIZE'(psum_q[c])
                                         : acc_sum[c][OBUF_DATA_SIZE-1:0];
        end
    end

    // Row fetch is staged one cycle ahead of the psum adders to keep the add path short.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            in_q         <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            fetch_done_q <= 1'b0;
            stage_vld_q  <= 1'b0;
            stage_q      <= '0;
            for (int c = 0; c < ELEMENTS; c++) begin
                psum_q[c] <= '0;
                acc_q[c]  <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_we) begin
                        for (int b = 0; b < NUM_ADDR; b++) begin
                            if (int'(i_addr) == b) in_q[b*BUS_WIDTH +: BUS_WIDTH] <= i_data;
                        end
                    end
                    if (i_start) begin
                        state_q      <= COMPUTE;
                        ready_q      <= 1'b0;
                        row_q        <= '0;
                        fetch_done_q <= 1'b0;
                        stage_vld_q  <= 1'b0;
                        for (int c = 0; c < ELEMENTS; c++) psum_q[c] <= '0;
                    end
                end
                COMPUTE: begin
                    if (stage_vld_q) begin
                        for (int c = 0; c < ELEMENTS; c++) begin
                            psum_q[c] <= psum_q[c] + PW'(stage_q[c*DATA_SIZE +: DATA_SIZE]);
                        end
                    end
                    if (!fetch_done_q) begin
                        stage_q     <= in_q[row_q] ? w_row : '0;
                        stage_vld_q <= 1'b1;
                        row_q       <= row_q + 1'b1;
                        if (row_q == RW'(XBAR_SIZE - 1)) fetch_done_q <= 1'b1;
                    end else begin
                        stage_vld_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int c = 0; c < ELEMENTS; c++) acc_q[c] <= acc_d[c];
                    plane_q <= (plane_q == PLW'(DATA_SIZE - 1)) ? '0 : plane_q + 1'b1;
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = ready_q;

    // Channels that map past the last column read as zero.
    always_comb begin
        o_data = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int e = 0; e < ELEMENTS; e++) begin
                if (int'(i_obuf_addr) * NUM_CHANNELS + ch == e) begin
                    o_data[ch*OBUF_DATA_SIZE +: OBUF_DATA_SIZE] = acc_q[e];
                end
            end
        end
    end

endmodule

// File: tb/tb_cim_xbar_tile.sv
// Scoreboard bench for cim_xbar_tile: golden dot-product model feeds an expected-result queue.
module tb_cim_xbar_tile;

    logic        clk;
    logic        rst;
    logic        i_we;
    logic [1:0]  i_addr;
    logic [3:0]  i_data;
    logic        i_start;
    logic        o_ready;
    logic        i_w_we;
    logic [3:0]  i_w_row;
    logic [1:0]  i_w_col;
    logic [3:0]  i_w_data;
    logic        i_obuf_addr;
    logic [23:0] o_data;

    cim_xbar_tile dut (
        .clk         (clk),
        .rst         (rst),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_start     (i_start),
        .o_ready     (o_ready),
        .i_w_we      (i_w_we),
        .i_w_row     (i_w_row),
        .i_w_col     (i_w_col),
        .i_w_data    (i_w_data),
        .i_obuf_addr (i_obuf_addr),
        .o_data      (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          exp_q[$];
    int          xv[16];
    int          wm[16][4];
    int          lowc[4];
    logic [11:0] got[4];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_weights();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                i_w_we   = 1'b1;
                i_w_row  = 4'(r);
                i_w_col  = 2'(c);
                i_w_data = 4'(wm[r][c]);
            end
        end
        @(negedge clk);
        i_w_we = 1'b0;
    endtask

    task automatic write_plane(input logic [15:0] bits);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            i_we   = 1'b1;
            i_addr = 2'(b);
            i_data = bits[b*4 +: 4];
        end
        @(negedge clk);
        i_we = 1'b0;
    endtask

    // Golden model: unsigned dot product of the first np bit-planes of xv with wm.
    task automatic push_expected(input int np);
        for (int c = 0; c < 4; c++) begin
            int e;
            e = 0;
            for (int p = 0; p < np; p++) begin
                for (int r = 0; r < 16; r++) begin
                    if (((xv[r] >> p) & 1) == 1) e += wm[r][c] << p;
                end
            end
            exp_q.push_back(e % 4096);
        end
    endtask

    // Sends np planes LSB first; lowc[p] records how many cycles o_ready stayed low.
    task automatic infer(input int np, input bit disturb);
        push_expected(np);
        for (int p = 0; p < np; p++) begin
            logic [15:0] bits;
            int cnt;
            for (int r = 0; r < 16; r++) bits[r] = ((xv[r] >> p) & 1) == 1;
            write_plane(bits);
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            cnt = 0;
            while (!o_ready && cnt < 100) begin
                cnt++;
                if (disturb && cnt == 5) begin
                    i_we     = 1'b1;
                    i_addr   = 2'(p);
                    i_data   = ~bits[p*4 +: 4];
                    i_w_we   = 1'b1;
                    i_w_row  = 4'(p + 3);
                    i_w_col  = 2'(p);
                    i_w_data = ~4'(wm[p+3][p]);
                    i_start  = 1'b1;
                end else begin
                    i_we    = 1'b0;
                    i_w_we  = 1'b0;
                    i_start = 1'b0;
                end
                @(negedge clk);
            end
            i_we    = 1'b0;
            i_w_we  = 1'b0;
            i_start = 1'b0;
            lowc[p] = cnt;
        end
    endtask

    task automatic read_obuf();
        for (int a = 0; a < 2; a++) begin
            i_obuf_addr = a[0];
            #1;
            got[2*a]   = o_data[11:0];
            got[2*a+1] = o_data[23:12];
        end
    endtask

    task automatic test_reset();
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", o_ready);
        end
        read_obuf();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (got[c] !== 12'd0) begin
                bad++;
                $display("FAIL reset_acc%0d got=%0d want=0", c, got[c]);
            end
        end
    endtask

    task automatic test_ones();
        for (int r = 0; r < 16; r++) begin
            xv[r] = 1;
            for (int c = 0; c < 4; c++) wm[r][c] = 1;
        end
        load_weights();
        infer(1, 1'b0);
        total++;
        if (lowc[0] != 18) begin
            bad++;
            $display("FAIL ones_latency got=%0d want=18", lowc[0]);
        end
        read_obuf();
        for (int c = 0; c < 4; c++) begin
            int e;
            e = exp_q.pop_front();
            total++;
            if (got[c] !== 12'(e)) begin
                bad++;
                $display("FAIL ones_col%0d got=%0d want=%0d", c, got[c], e);
            end
        end
        do_reset();
    endtask

    task automatic test_full_scale();
        for (int r = 0; r < 16; r++) begin
            xv[r] = 15;
            for (int c = 0; c < 4; c++) wm[r][c] = 15;
        end
        load_weights();
        infer(4, 1'b0);
        for (int p = 0; p < 4; p++) begin
            total++;
            if (lowc[p] != 18) begin
                bad++;
                $display("FAIL full_latency_p%0d got=%0d want=18", p, lowc[p]);
            end
        end
        read_obuf();
        for (int c = 0; c < 4; c++) begin
            int e;
            e = exp_q.pop_front();
            total++;
            if (got[c] !== 12'(e) || got[c] !== 12'hE10) begin
                bad++;
                $display("FAIL full_col%0d got=%0d want=%0d", c, got[c], e);
            end
        end
    endtask

    task automatic test_ramp();
        for (int r = 0; r < 16; r++) begin
            xv[r] = r;
            for (int c = 0; c < 4; c++) wm[r][c] = (r + c) & 15;
        end
        load_weights();
        infer(4, 1'b0);
        read_obuf();
        total++;
        if (got[0] !== 12'd1240) begin
            bad++;
            $display("FAIL ramp_col0_const got=%0d want=1240", got[0]);
        end
        for (int c = 0; c < 4; c++) begin
            int e;
            e = exp_q.pop_front();
            total++;
            if (got[c] !== 12'(e)) begin
                bad++;
                $display("FAIL ramp_col%0d got=%0d want=%0d", c, got[c], e);
            end
        end
    endtask

    task automatic test_busy_ignore();
        for (int r = 0; r < 16; r++) begin
            xv[r] = int'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) wm[r][c] = int'($urandom_range(0, 15));
        end
        load_weights();
        infer(4, 1'b1);
        for (int p = 0; p < 4; p++) begin
            total++;
            if (lowc[p] != 18) begin
                bad++;
                $display("FAIL busy_latency_p%0d got=%0d want=18", p, lowc[p]);
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL busy_no_extra_start got=%b want=1", o_ready);
        end
        read_obuf();
        for (int c = 0; c < 4; c++) begin
            int e;
            e = exp_q.pop_front();
            total++;
            if (got[c] !== 12'(e)) begin
                bad++;
                $display("FAIL busy_col%0d got=%0d want=%0d", c, got[c], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        write_plane(16'hFFFF);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready got=%b want=1", o_ready);
        end
        read_obuf();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (got[c] !== 12'd0) begin
                bad++;
                $display("FAIL midrst_acc%0d got=%0d want=0", c, got[c]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 16; r++) begin
            xv[r] = int'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) wm[r][c] = int'($urandom_range(0, 15));
        end
        load_weights();
        infer(4, 1'b0);
        read_obuf();
        for (int c = 0; c < 4; c++) begin
            int e;
            e = exp_q.pop_front();
            total++;
            if (got[c] !== 12'(e)) begin
                bad++;
                $display("FAIL midrst_col%0d got=%0d want=%0d", c, got[c], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 4; c++) wm[r][c] = int'($urandom_range(0, 15));
        end
        load_weights();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 16; r++) xv[r] = (k == 0) ? 15 - r : int'($urandom_range(0, 15));
            infer(4, 1'b0);
            read_obuf();
            for (int c = 0; c < 4; c++) begin
                int e;
                e = exp_q.pop_front();
                total++;
                if (got[c] !== 12'(e)) begin
                    bad++;
                    $display("FAIL b2b%0d_col%0d got=%0d want=%0d", k, c, got[c], e);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        i_we        = 1'b0;
        i_addr      = '0;
        i_data      = '0;
        i_start     = 1'b0;
        i_w_we      = 1'b0;
        i_w_row     = '0;
        i_w_col     = '0;
        i_w_data    = '0;
        i_obuf_addr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_ones();
        test_full_scale();
        test_ramp();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
